// File: rtl/riscv_ctrl_pkg.sv
// Shared control-path definitions for the branch redirect controller:
// FSM state encoding, shadow-window limits and the target alignment mask.
package riscv_ctrl_pkg;

   // Redirect sequencer states: idle/accepting, redirect held by a stall,
   // wrong-path shadow window.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PEND   = 2'd1,
      SHADOW = 2'd2
   } redir_state_e;

   // Longest shadow window the counter is sized for.
   localparam int SHADOW_MAX = 3;

   // Width of the shadow down-counter, derived from SHADOW_MAX.
   localparam int SHADOW_CNT_W = $clog2(SHADOW_MAX + 1);

   // Low target bits that must be zero for a word-aligned fetch.
   localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/branch_redirect_ctrl_if.sv
// Signal bundle between the EX-stage branch unit / hazard logic and the
// branch redirect controller. The statistics counters only exist when
// BRANCH_REDIRECT_STATS_EN is defined.
interface branch_redirect_ctrl_if #(
   parameter int PC_W = 9
);
   // EX stage and hazard unit side
   logic            ex_valid;
   logic            ex_pc_sel;
   logic [31:0]     ex_br_pc;
   logic            stall_req;

   // PC register and pipeline flush side
   logic            pc_sel_o;
   logic [PC_W-1:0] pc_target_o;
   logic            flush_ifid;
   logic            flush_idex;
   logic            pc_hold;
   logic            misalign_o;

`ifdef BRANCH_REDIRECT_STATS_EN
   logic [15:0]     redir_cnt;
   logic [15:0]     stall_redir_cnt;

   // Producer of the branch decisions and stalls.
   modport master (
      output ex_valid, ex_pc_sel, ex_br_pc, stall_req,
      input  pc_sel_o, pc_target_o, flush_ifid, flush_idex, pc_hold,
             misalign_o, redir_cnt, stall_redir_cnt
   );

   // The redirect controller itself.
   modport slave (
      input  ex_valid, ex_pc_sel, ex_br_pc, stall_req,
      output pc_sel_o, pc_target_o, flush_ifid, flush_idex, pc_hold,
             misalign_o, redir_cnt, stall_redir_cnt
   );
`else
   // Producer of the branch decisions and stalls.
   modport master (
      output ex_valid, ex_pc_sel, ex_br_pc, stall_req,
      input  pc_sel_o, pc_target_o, flush_ifid, flush_idex, pc_hold,
             misalign_o
   );

   // The redirect controller itself.
   modport slave (
      input  ex_valid, ex_pc_sel, ex_br_pc, stall_req,
      output pc_sel_o, pc_target_o, flush_ifid, flush_idex, pc_hold,
             misalign_o
   );
`endif

endinterface

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating event counter used by the optional redirect statistics.
// Only compiled when BRANCH_REDIRECT_STATS_EN is defined.
`ifdef BRANCH_REDIRECT_STATS_EN
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q;

   // Count events, sticking at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign count = cnt_q;

endmodule
`endif

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: turns a taken EX-stage branch into a fetch PC
// redirect plus IF/ID and ID/EX flushes, holds the target across stalls and
// then ignores wrong-path EX results for SHADOW_CYC unstalled cycles.
// Optional macro BRANCH_REDIRECT_STATS_EN adds saturating redirect counters.
module branch_redirect_ctrl
   import riscv_ctrl_pkg::*;
#(
   parameter int PC_W       = 9,
   parameter int SHADOW_CYC = 2   // legal range 1..SHADOW_MAX
) (
   input  logic                  clk,
   input  logic                  reset,
   branch_redirect_ctrl_if.slave bus
);

   localparam logic [SHADOW_CNT_W-1:0] SHADOW_INIT = SHADOW_CNT_W'(SHADOW_CYC - 1);

   redir_state_e             state_q;
   logic [PC_W-1:0]          pend_target_q;
   logic [SHADOW_CNT_W-1:0]  shadow_cnt_q;
   logic                     misalign_q;

   logic                     take;
   logic [PC_W-1:0]          br_target;
   logic                     pc_sel;
   logic [PC_W-1:0]          pc_target;
   logic                     flush_ifid;
   logic                     flush_idex;
   logic                     pc_hold;

   // Upper target bits are intentionally discarded.
   logic                     unused_upper_pc;
   assign unused_upper_pc = ^bus.ex_br_pc[31:PC_W];

   assign br_target = bus.ex_br_pc[PC_W-1:0];
   assign take      = (state_q == RUN) && bus.ex_valid && bus.ex_pc_sel;

   // Same-cycle redirect, flush and hold decisions from the current state.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      pc_sel     = 1'b0;
      pc_target  = '0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      pc_hold    = 1'b0;
      if (!reset) begin
         unique case (state_q)
            RUN: begin
               pc_hold = bus.stall_req;
               if (take) begin
                  pc_target = br_target;
                  if (!bus.stall_req) begin
                     pc_sel     = 1'b1;
                     flush_ifid = 1'b1;
                     flush_idex = 1'b1;
                  end
               end
            end
            PEND: begin
               pc_target = pend_target_q;
               if (bus.stall_req) begin
                  pc_hold = 1'b1;
               end else begin
                  pc_sel     = 1'b1;
                  flush_ifid = 1'b1;
                  flush_idex = 1'b1;
               end
            end
            SHADOW: begin
               pc_hold = bus.stall_req;
            end
            default: begin
               pc_hold = 1'b0;
            end
         endcase
      end
   end

   // Sequencer state, held target, shadow counter and sticky misalign flag.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q       <= RUN;
         pend_target_q <= '0;
         shadow_cnt_q  <= '0;
         misalign_q    <= 1'b0;
      end else begin
         if (pc_sel && ((pc_target[1:0] & ADDR_ALIGN_MASK) != 2'b00)) begin
            misalign_q <= 1'b1;
         end
         unique case (state_q)
            RUN: begin
               if (take) begin
                  if (bus.stall_req) begin
                     pend_target_q <= br_target;
                     state_q       <= PEND;
                  end else begin
                     shadow_cnt_q <= SHADOW_INIT;
                     state_q      <= SHADOW;
                  end
               end
            end
            PEND: begin
               if (!bus.stall_req) begin
                  shadow_cnt_q <= SHADOW_INIT;
                  state_q      <= SHADOW;
               end
            end
            SHADOW: begin
               if (!bus.stall_req) begin
                  if (shadow_cnt_q == '0) begin
                     state_q <= RUN;
                  end else begin
                     shadow_cnt_q <= shadow_cnt_q - 1'b1;
                  end
               end
            end
            default: begin
               state_q <= RUN;
            end
         endcase
      end
   end

   assign bus.pc_sel_o    = pc_sel;
   assign bus.pc_target_o = pc_target;
   assign bus.flush_ifid  = flush_ifid;
   assign bus.flush_idex  = flush_idex;
   assign bus.pc_hold     = pc_hold;
   assign bus.misalign_o  = misalign_q;

`ifdef BRANCH_REDIRECT_STATS_EN
   logic stall_redir_evt;
   assign stall_redir_evt = take && bus.stall_req && !reset;

   sat_counter #(.WIDTH(16)) u_redir_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (pc_sel),
      .count (bus.redir_cnt)
   );

   sat_counter #(.WIDTH(16)) u_stall_redir_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_redir_evt),
      .count (bus.stall_redir_cnt)
   );
`endif

endmodule
